// File: rtl/ysyx_24100006_isa_pkg.sv
// ysyx_24100006_isa_pkg: RV32 opcode constants and immediate-format encoding shared by IDU and EXU
package ysyx_24100006_isa_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;
endpackage

// File: rtl/ysyx_24100006_immgen.sv
// ysyx_24100006_immgen: sign-extended immediate assembly for each RV32 instruction format
module ysyx_24100006_immgen
  import ysyx_24100006_isa_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);
  // select the format's bit scatter and sign-extend to XLEN
  always_comb begin
    imm = imm_type == IMM_I ? XLEN'($signed(inst[31:20])) :
          imm_type == IMM_S ? XLEN'($signed({inst[31:25], inst[11:7]})) :
          imm_type == IMM_B ? XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})) :
          imm_type == IMM_U ? XLEN'($signed({inst[31:12], 12'b0})) :
          imm_type == IMM_J ? XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})) :
          '0;
  end
endmodule

// File: rtl/ysyx_24100006_idu_rx.sv
// ysyx_24100006_idu_rx: one-entry decode buffer between fetch and execute with RV32E field decode
module ysyx_24100006_idu_rx
  import ysyx_24100006_isa_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] pc_F,
  input  logic [31:0]     instruction,
  input  logic            flush,
  output logic            id_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] pc_D,
  output logic [31:0]     inst_D,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            illegal
);
  localparam logic [5:0] NREG_L = 6'(NREG);
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            accept, drain;
  logic            known, use_rd, use_rs1, use_rs2;
  imm_type_e       imm_t;
  // state and buffer registers; reset drops any buffered entry
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end
  // next state: flush wins, then a new accept, then a drain empties the buffer
  always_comb begin
    valid_d = flush ? 1'b0 : accept ? 1'b1 : drain ? 1'b0 : valid_q;
    pc_d    = accept ? pc_F : pc_q;
    inst_d  = accept ? instruction : inst_q;
  end
  // handshake outputs; ready while empty or while the held entry leaves this cycle
  always_comb begin
    id_valid = valid_q;
    id_ready = ~valid_q | ex_ready;
    accept   = if_valid & id_ready & ~flush;
    drain    = valid_q & ex_ready;
  end
  assign pc_D   = pc_q;
  assign inst_D = inst_q;
  assign opcode = inst_q[6:0];
  assign rd     = inst_q[11:7];
  assign funct3 = inst_q[14:12];
  assign rs1    = inst_q[19:15];
  assign rs2    = inst_q[24:20];
  assign funct7 = inst_q[31:25];
  // classify opcode into immediate format and which register fields it uses
  always_comb begin
    known   = 1'b1;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm_t   = IMM_NONE;
    case (opcode)
      OPC_OP: begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin use_rd = 1'b1; use_rs1 = 1'b1; imm_t = IMM_I; end
      OPC_STORE: begin use_rs1 = 1'b1; use_rs2 = 1'b1; imm_t = IMM_S; end
      OPC_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; imm_t = IMM_B; end
      OPC_LUI, OPC_AUIPC: begin use_rd = 1'b1; imm_t = IMM_U; end
      OPC_JAL: begin use_rd = 1'b1; imm_t = IMM_J; end
      default: known = 1'b0;
    endcase
  end
  assign imm_type = imm_t;
  assign illegal  = valid_q & (~known |
                    (use_rd  & ({1'b0, rd}  >= NREG_L)) |
                    (use_rs1 & ({1'b0, rs1} >= NREG_L)) |
                    (use_rs2 & ({1'b0, rs2} >= NREG_L)));
  ysyx_24100006_immgen #(.XLEN(XLEN)) u_immgen (
    .inst     (inst_q),
    .imm_type (imm_t),
    .imm      (imm)
  );
endmodule
